scan_chain_loader: RTL and testbench

SCAN_CHAIN_LOADER -- requirements
Module: scan_chain_loader

---
 rtl/scan_chain_loader.sv | 153 +++++++++++++++
 tb/tb_scan_chain_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_loader.sv
// Scan chain loader: streams bytes from a valid/ready source into a serial
// configuration chain LSB first, optionally comparing the chain tail on readback.
module scan_chain_loader #(
    parameter int CHAIN_LEN = 29,
    parameter int CNT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       verify,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       scan_clk,
    output logic       scan_en,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LEN_C  = CNT_WIDTH'(CHAIN_LEN);
    localparam logic [CNT_WIDTH-1:0] ONE_C  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] ZERO_C = {CNT_WIDTH{1'b0}};

    state_t               state_r;
    state_t               state_s;
    logic [CNT_WIDTH-1:0] bit_cnt_r;
    logic [CNT_WIDTH-1:0] cnt_inc_s;
    logic [2:0]           bit_idx_r;
    logic [7:0]           shifter_r;
    logic                 verify_r;
    logic                 take_s;
    logic                 in_ready_r;
    logic                 scan_clk_r;
    logic                 scan_en_r;
    logic                 scan_in_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;

    assign cnt_inc_s = bit_cnt_r + ONE_C;

    assign in_ready = in_ready_r;
    assign scan_clk = scan_clk_r;
    assign scan_en  = scan_en_r;
    assign scan_in  = scan_in_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

    // Next-state decode; abort overrides every handshake and transition
    always_comb begin
        state_s = state_r;
        take_s  = 1'b0;
        if (abort && (state_r != IDLE)) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s = FETCH;
                    end else begin
                        state_s = IDLE;
                    end
                end
                FETCH: begin
                    if (in_valid && in_ready_r) begin
                        take_s  = 1'b1;
                        state_s = SHIFT_LO;
                    end else begin
                        state_s = FETCH;
                    end
                end
                SHIFT_LO: state_s = SHIFT_HI;
                SHIFT_HI: begin
                    if (cnt_inc_s == LEN_C) begin
                        state_s = DONE;
                    end else if (bit_idx_r == 3'd7) begin
                        state_s = FETCH;
                    end else begin
                        state_s = SHIFT_LO;
                    end
                end
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State, datapath and outputs; outputs are decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            bit_cnt_r  <= ZERO_C;
            bit_idx_r  <= 3'd0;
            shifter_r  <= 8'h00;
            verify_r   <= 1'b0;
            in_ready_r <= 1'b0;
            scan_clk_r <= 1'b0;
            scan_en_r  <= 1'b0;
            scan_in_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == FETCH);
            scan_en_r  <= (state_s == FETCH) || (state_s == SHIFT_LO) || (state_s == SHIFT_HI);
            scan_clk_r <= (state_s == SHIFT_HI);
            busy_r     <= (state_s != IDLE);
            done_r     <= (state_s == DONE);

            if ((state_r == IDLE) && start) begin
                verify_r  <= verify;
                err_r     <= 1'b0;
                bit_cnt_r <= ZERO_C;
            end

            if (take_s) begin
                shifter_r <= in_data;
                bit_idx_r <= 3'd0;
                scan_in_r <= in_data[0];
            end

            // shifter_r[0] is the bit currently presented on scan_in
            if ((state_r == SHIFT_LO) && (state_s == SHIFT_HI) && verify_r &&
                (scan_out != shifter_r[0])) begin
                err_r <= 1'b1;
            end

            if ((state_r == SHIFT_HI) && (state_s != IDLE)) begin
                bit_cnt_r <= cnt_inc_s;
                shifter_r <= {1'b0, shifter_r[7:1]};
                if (state_s == SHIFT_LO) begin
                    bit_idx_r <= bit_idx_r + 3'd1;
                    scan_in_r <= shifter_r[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_chain_loader.sv
// Self-checking bench for scan_chain_loader: a 29-bit chain with a behavioural
// chain model on the tail, plus an 8-bit instance for the single-byte case.
module tb_scan_chain_loader;

    localparam int L  = 29;
    localparam int NB = (L + 7) / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, verify, abort, in_valid;
    logic [7:0] in_data;
    logic       in_ready, scan_clk, scan_en, scan_in, scan_out, busy, done, err;

    logic       s8_start, s8_in_valid, s8_low;
    logic [7:0] s8_in_data;
    logic       s8_in_ready, s8_scan_clk, s8_scan_en, s8_scan_in, s8_busy, s8_done, s8_err;

    logic [L-1:0] chain = '0;
    bit           got_bits[$];
    bit           got8[$];
    bit           prev_bits[$];
    logic [7:0]   stim[$];
    int           checks   = 0;
    int           failures = 0;

    scan_chain_loader #(.CHAIN_LEN(L), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .verify(verify), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .scan_clk(scan_clk), .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
        .busy(busy), .done(done), .err(err)
    );

    scan_chain_loader #(.CHAIN_LEN(8), .CNT_WIDTH(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .verify(s8_low), .abort(s8_low),
        .in_data(s8_in_data), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
        .scan_clk(s8_scan_clk), .scan_en(s8_scan_en), .scan_in(s8_scan_in), .scan_out(s8_low),
        .busy(s8_busy), .done(s8_done), .err(s8_err)
    );

    // The target chain: a plain shift register clocked by scan_clk
    always @(posedge scan_clk) begin
        chain <= {chain[L-2:0], scan_in};
        got_bits.push_back(scan_in);
    end
    assign scan_out = chain[L-1];

    always @(posedge s8_scan_clk) got8.push_back(s8_scan_in);

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; verify = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        s8_start = 1'b0; s8_in_valid = 1'b0; s8_in_data = 8'h00; s8_low = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, scan_clk, scan_en, scan_in, busy, done, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000000",
                     {in_ready, scan_clk, scan_en, scan_in, busy, done, err});
        end
        checks++;
        if ({s8_in_ready, s8_scan_clk, s8_scan_en, s8_scan_in, s8_busy, s8_done, s8_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs8 got=%b exp=0000000",
                     {s8_in_ready, s8_scan_clk, s8_scan_en, s8_scan_in, s8_busy, s8_done, s8_err});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One pass over stim[]; optional in_valid gap, stray start pulse, or abort
    task automatic run_pass(input string name, input bit v, input int gap_at, input int gap_len,
                            input int start_at, input int abort_at);
        bit           exp_bits[$];
        bit           exp_err, will_take, aborted, seen_done;
        logic [7:0]   b;
        logic [L-1:0] got_v, exp_v;
        logic         err_at_done;
        int           edge_n, done_edge, done_cnt, hs, ptr, gap_left, exp_edge;
        exp_bits = {};
        for (int i = 0; i < L; i++) begin
            b = stim[i / 8];
            exp_bits.push_back(b[i % 8]);
        end
        exp_err = 1'b0;
        for (int i = 0; i < L; i++) if (v && (exp_bits[i] != prev_bits[i])) exp_err = 1'b1;
        got_bits = {};
        edge_n = 0; done_edge = -1; done_cnt = 0; hs = 0; ptr = 0; gap_left = gap_len;
        aborted = 1'b0; err_at_done = 1'bx;
        @(negedge clk);
        start = 1'b1; verify = v; in_valid = 1'b0; abort = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; verify = 1'($urandom);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done === 1'b1) begin
                done_cnt++;
                done_edge = edge_n;
                err_at_done = err;
            end
            if (done_edge >= 0 && edge_n == done_edge + 1) break;
            start = (edge_n == start_at);
            abort = (edge_n == abort_at);
            if (hs == gap_at && gap_left > 0 && in_ready === 1'b1) begin
                in_valid = 1'b0;
                gap_left--;
                checks++;
                if (scan_clk !== 1'b0 || scan_en !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_gap_hold scan_clk=%b scan_en=%b exp 0/1", name, scan_clk, scan_en);
                end
            end else if (ptr < stim.size()) begin
                in_valid = 1'b1;
                in_data  = stim[ptr];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            will_take = in_valid && (in_ready === 1'b1);
            @(posedge clk);
            edge_n++;
            if (will_take) begin
                ptr++;
                hs++;
            end
            @(negedge clk);
            if (abort === 1'b1) begin
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        if (aborted) begin
            checks++;
            if ({scan_clk, scan_en, in_ready, busy, done} !== 5'b0) begin
                failures++;
                $display("FAIL %s_idle got=%b exp=00000", name, {scan_clk, scan_en, in_ready, busy, done});
            end
            checks++;
            if (err !== (v && (exp_bits[0] != prev_bits[0]))) begin
                failures++;
                $display("FAIL %s_err_held got=%b exp=%b", name, err, v && (exp_bits[0] != prev_bits[0]));
            end
            seen_done = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (done !== 1'b0) seen_done = 1'b1;
            end
            checks++;
            if (seen_done) begin
                failures++;
                $display("FAIL %s_no_done got=1 exp=0", name);
            end
        end else begin
            exp_edge = 2 * L + NB + gap_len;
            checks++;
            if (done_edge != exp_edge) begin
                failures++;
                $display("FAIL %s_done_edge got=%0d exp=%0d", name, done_edge, exp_edge);
            end
            checks++;
            if (done_cnt != 1) begin
                failures++;
                $display("FAIL %s_done_pulses got=%0d exp=1", name, done_cnt);
            end
            checks++;
            if (hs != NB) begin
                failures++;
                $display("FAIL %s_handshakes got=%0d exp=%0d", name, hs, NB);
            end
            checks++;
            if (got_bits.size() != L) begin
                failures++;
                $display("FAIL %s_scan_rises got=%0d exp=%0d", name, got_bits.size(), L);
            end
            got_v = '0;
            exp_v = '0;
            for (int i = 0; i < L; i++) begin
                if (i < got_bits.size()) got_v[i] = got_bits[i];
                exp_v[i] = exp_bits[i];
            end
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL %s_scan_bits got=%h exp=%h", name, got_v, exp_v);
            end
            checks++;
            if (err_at_done !== exp_err) begin
                failures++;
                $display("FAIL %s_err got=%b exp=%b", name, err_at_done, exp_err);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s_busy_after got=%b exp=0", name, busy);
            end
            prev_bits = exp_bits;
        end
    endtask

    task automatic test_load();
        stim = {8'hA5, 8'h3C, 8'hFF, 8'h1F};
        run_pass("load", 1'b0, -1, 0, -1, -1);
    endtask

    task automatic test_verify();
        run_pass("verify_same", 1'b1, -1, 0, -1, -1);
        stim[2] = 8'hFE;
        run_pass("verify_diff", 1'b1, -1, 0, -1, -1);
    endtask

    task automatic test_gap();
        run_pass("gap", 1'b0, 2, 5, -1, -1);
    endtask

    task automatic test_back_to_back_start();
        stim = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_pass("start_busy", 1'b0, -1, 0, 20, -1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            stim = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            run_pass("random", 1'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, 6)), -1, -1);
        end
    endtask

    task automatic test_abort();
        logic [7:0] b;
        stim = {};
        for (int k = 0; k < NB; k++) begin
            b = 8'($urandom);
            for (int j = 0; j < 8; j++) if (8 * k + j < L) b[j] = !prev_bits[8 * k + j];
            stim.push_back(b);
        end
        run_pass("abort", 1'b1, -1, 0, -1, 10);
    endtask

    task automatic test_reset_shift_hi();
        bit found;
        @(negedge clk);
        start = 1'b1; verify = 1'b0; in_valid = 1'b1; in_data = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (scan_clk === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rst_shift_hi_reach got=0 exp=1");
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({scan_clk, scan_en, busy, in_ready, scan_in, done, err} !== 7'b0) begin
            failures++;
            $display("FAIL rst_shift_hi got=%b exp=0000000",
                     {scan_clk, scan_en, busy, in_ready, scan_in, done, err});
        end
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        int  edge_n, done_edge, done_cnt, hs;
        bit  will_take, extra;
        logic [7:0] got_v;
        got8 = {};
        edge_n = 0; done_edge = -1; done_cnt = 0; hs = 0; extra = 1'b0;
        @(negedge clk);
        s8_start = 1'b1; s8_in_valid = 1'b1; s8_in_data = 8'h81;
        @(posedge clk);
        @(negedge clk);
        s8_start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (s8_done === 1'b1) begin
                done_cnt++;
                done_edge = edge_n;
            end
            if (done_edge >= 0 && edge_n == done_edge + 1) break;
            if (hs >= 1 && s8_in_ready === 1'b1) extra = 1'b1;
            if (hs >= 1) s8_in_data = 8'($urandom);
            will_take = s8_in_valid && (s8_in_ready === 1'b1);
            @(posedge clk);
            edge_n++;
            if (will_take) hs++;
            @(negedge clk);
        end
        s8_in_valid = 1'b0;
        checks++;
        if (hs != 1) begin
            failures++;
            $display("FAIL single_handshakes got=%0d exp=1", hs);
        end
        checks++;
        if (extra) begin
            failures++;
            $display("FAIL single_refetch got=1 exp=0");
        end
        checks++;
        if (done_edge != 17) begin
            failures++;
            $display("FAIL single_done_edge got=%0d exp=17", done_edge);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL single_done_pulses got=%0d exp=1", done_cnt);
        end
        got_v = 8'h00;
        for (int i = 0; i < 8 && i < got8.size(); i++) got_v[i] = got8[i];
        checks++;
        if (got8.size() != 8 || got_v !== 8'h81) begin
            failures++;
            $display("FAIL single_bits got=%h/%0d exp=81/8", got_v, got8.size());
        end
    endtask

    initial begin
        prev_bits = {};
        for (int i = 0; i < L; i++) prev_bits.push_back(1'b0);
        test_reset();
        test_load();
        test_verify();
        test_gap();
        test_back_to_back_start();
        test_random();
        test_abort();
        test_reset_shift_hi();
        test_single_byte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
